// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state/result types and sizing helpers for the sequential comparator.
package cmp_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} cmp_state_t;

   typedef struct packed {
      logic eq;
      logic ab;
      logic ba;
   } cmp_res_t;

   localparam cmp_res_t RES_EQ = 3'b100;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_width(input int width, input int digit);
      return $clog2(width / digit + 1);
   endfunction

endpackage

// File: rtl/cmp_digit.sv
// cmp_digit: combinational MSB-first compare of one DIGIT-bit slice, gated by the incoming equality.
module cmp_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             eqi,
   output logic             eq,
   output logic             ab,
   output logic             ba
);
   logic [DIGIT-1:0] w_gt, w_lt;

   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      assign w_gt[i] = a_d[i] & ~b_d[i];
      assign w_lt[i] = ~a_d[i] & b_d[i];
   end

   // Only the first differing bit below an unbroken equal prefix may decide.
   always_comb begin
      eq = eqi;
      ab = 1'b0;
      ba = 1'b0;
      for (int k = DIGIT - 1; k >= 0; k--) begin
         ab = ab | (eq & w_gt[k]);
         ba = ba | (eq & w_lt[k]);
         eq = eq & ~(w_gt[k] | w_lt[k]);
      end
   end

endmodule

// File: rtl/seq_cmp.sv
// seq_cmp: iterative MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned.
// Define SEQ_CMP_EARLY_EXIT_EN to finish as soon as the operands are known to differ.
module seq_cmp
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             ab,
   output logic             ba
);
   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = cnt_width(WIDTH, DIGIT);

   cmp_state_t       r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, w_flip;
   logic [CW-1:0]    r_cnt;
   cmp_res_t         r_run, r_res, w_run_n;
   logic             w_eq, w_ab, w_ba, w_last;

   cmp_digit #(.DIGIT(DIGIT)) u_dig (
      .a_d (r_a[WIDTH-1 -: DIGIT]),
      .b_d (r_b[WIDTH-1 -: DIGIT]),
      .eqi (r_run.eq),
      .eq  (w_eq),
      .ab  (w_ab),
      .ba  (w_ba)
   );

   // Inverting both sign bits maps two's-complement order onto unsigned order.
   assign w_flip  = WIDTH'(is_signed) << (WIDTH - 1);
   assign w_run_n = r_run.eq ? {w_eq, w_ab, w_ba} : r_run;

`ifdef SEQ_CMP_EARLY_EXIT_EN
   assign w_last = (r_cnt == CW'(1)) || !w_run_n.eq;
`else
   assign w_last = r_cnt == CW'(1);
`endif

   always_comb begin
      w_next = (r_state == IDLE) ? (start ? BUSY : IDLE) :
               (r_state == BUSY) ? (w_last ? DONE : BUSY) : IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_run <= RES_EQ;
         r_res <= RES_EQ;
      end else if (r_state == IDLE && start) begin
         r_a   <= a ^ w_flip;
         r_b   <= b ^ w_flip;
         r_cnt <= CW'(N);
         r_run <= RES_EQ;
      end else if (r_state == BUSY) begin
         r_a   <= r_a << DIGIT;
         r_b   <= r_b << DIGIT;
         r_cnt <= r_cnt - CW'(1);
         r_run <= w_run_n;
         if (w_last) r_res <= w_run_n;
      end
   end

   assign busy = r_state == BUSY;
   assign done = r_state == DONE;
   assign eq   = r_res.eq;
   assign ab   = r_res.ab;
   assign ba   = r_res.ba;

endmodule

// File: tb/tb_seq_cmp.sv
// tb_seq_cmp: self-checking bench for seq_cmp with a cycle-level reference model.
// Honours SEQ_CMP_EARLY_EXIT_EN when the design is built with it.
module tb_seq_cmp;
   logic        clk, rst, start, is_signed;
   logic [31:0] a, b;
   logic        busy, done, eq, ab, ba;
   logic        s_start, s_sg;
   logic [15:0] s_a, s_b;
   logic [2:0]  s_busy, s_done, s_eq, s_ab, s_ba;
   int          n_chk = 0, n_err = 0;
   logic        chk_en = 1'b0;
   logic        m_busy, m_done;
   logic [2:0]  m_res, m_pend;
   int          m_left;
   int          cov[3];

   seq_cmp #(.WIDTH(32), .DIGIT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(is_signed),
      .busy(busy), .done(done), .eq(eq), .ab(ab), .ba(ba)
   );

   for (genvar g = 0; g < 3; g++) begin : g16
      seq_cmp #(.WIDTH(16), .DIGIT(g == 0 ? 1 : g == 1 ? 8 : 16)) u (
         .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .is_signed(s_sg),
         .busy(s_busy[g]), .done(s_done[g]), .eq(s_eq[g]), .ab(s_ab[g]), .ba(s_ba[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Golden result {eq,ab,ba} from plain integer ordering of w-bit operands.
   function automatic logic [2:0] gold(input logic [31:0] x, input logic [31:0] y,
                                       input logic s, input int w);
      longint sx, sy;
      sx = longint'(x);
      sy = longint'(y);
      if (s && x[w-1]) sx = sx - (longint'(1) << w);
      if (s && y[w-1]) sy = sy - (longint'(1) << w);
      return sx == sy ? 3'b100 : sx > sy ? 3'b010 : 3'b001;
   endfunction

   // Number of compare cycles for the 32/4 instance.
   function automatic int lat(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_CMP_EARLY_EXIT_EN
      for (int i = 0; i < 8; i++)
         if (x[31 - 4*i -: 4] != y[31 - 4*i -: 4]) return i + 1;
`endif
      return 8;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= 3'b100;
         m_left <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end
         m_left <= m_left - 1;
      end else if (start) begin
         m_busy <= 1'b1;
         m_left <= lat(a, b);
         m_pend <= gold(a, b, is_signed, 32);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc busy", 32'(busy), 32'(m_busy));
         chk("cyc done", 32'(done), 32'(m_done));
         chk("cyc flags", 32'({eq, ab, ba}), 32'(m_res));
      end
   end

   task automatic run(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input logic [2:0] er, input int ee, input string nm);
      int n;
      a = x; b = y; is_signed = s; start = 1'b1;
      @(posedge clk); n = 1;
      @(negedge clk); start = 1'b0;
      while (!done && n < 40) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
      chk({nm, " edges"}, 32'(n), 32'(ee));
      chk({nm, " flags"}, 32'({eq, ab, ba}), 32'(er));
      @(negedge clk);
   endtask

   initial begin
      int dn[$];
      int n;
      logic [2:0] e;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
      s_start = 1'b0; s_a = '0; s_b = '0; s_sg = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst flags", 32'({eq, ab, ba}), 32'b100);
      @(negedge clk);
      chk_en = 1'b1;

      run(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b010, 9, "ugt");
      run(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, 9, "slt_min");
      run(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 9, "slt_m1");
      run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b010, 9, "ugt_ff");
      run(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b100, 9, "equal");
`ifdef SEQ_CMP_EARLY_EXIT_EN
      run(32'h1000_0000, 32'h0000_0000, 1'b0, 3'b010, 2, "early_top");
`else
      run(32'h1000_0000, 32'h0000_0000, 1'b0, 3'b010, 9, "early_top");
`endif
      run(32'h0000_0001, 32'h0000_0000, 1'b0, 3'b010, 9, "early_low");

      a = 32'd5; b = 32'd3; is_signed = 1'b0; start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 3) begin a = 32'd0; b = 32'hFFFF; end
         if (c == 8) begin a = 32'd5; b = 32'd3; end
         if (done) dn.push_back(c);
      end
      start = 1'b0;
      chk("hs pulses", 32'(dn.size()), 32'd2);
      if (dn.size() == 2) begin
         chk("hs first", 32'(dn[0]), 32'd9);
         chk("hs period", 32'(dn[1] - dn[0]), 32'd10);
      end
      chk("hs flags", 32'({eq, ab, ba}), 32'b010);
      repeat (12) @(negedge clk);

      a = 32'd1; b = 32'd0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst done", 32'(done), 32'd0);
      chk("mid rst flags", 32'({eq, ab, ba}), 32'b100);
      @(negedge clk); rst = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("no done after rst", 32'(n), 32'd0);
      run(32'd5, 32'd3, 1'b0, 3'b010, 9, "post_rst");

      for (int it = 0; it < 36; it++) begin
         s_a  = 16'($urandom);
         s_b  = ($urandom_range(9) < 4) ? s_a : 16'($urandom);
         s_sg = it[0];
         if (it == 0) begin s_a = 16'h8000; s_b = 16'h0001; end
         e = gold(32'(s_a), 32'(s_b), s_sg, 16);
         for (int k = 0; k < 3; k++) if (e[2-k]) cov[k]++;
         s_start = 1'b1;
         @(posedge clk);
         @(negedge clk); s_start = 1'b0;
         n = 0;
         while (|s_busy && n < 30) begin
            @(negedge clk);
            n++;
         end
         chk("sw timeout", 32'(n < 30), 32'd1);
         for (int g = 0; g < 3; g++)
            chk($sformatf("sw d%0d %h %h s%0d", g, s_a, s_b, s_sg),
                32'({s_eq[g], s_ab[g], s_ba[g]}), 32'(e));
         @(negedge clk);
      end
      chk("cov eq", 32'(cov[0] >= 1), 32'd1);
      chk("cov ab", 32'(cov[1] >= 1), 32'd1);
      chk("cov ba", 32'(cov[2] >= 1), 32'd1);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_cmp.md
Name: seq_cmp

Overview:
- Iterative magnitude comparator for the execute stage's branch and set-less-than path.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, using a cascaded compare-cell chain over each digit.
- Supports unsigned and two's-complement signed modes.
- Uses a start/done handshake; results are held until the next accepted start.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- is_signed  in  1  1 selects two's-complement compare; sampled with the operands.
- busy  out  1  a compare is in progress.
- done  out  1  one-cycle pulse when results become valid.
- eq  out  1  A == B.
- ab  out  1  A > B.
- ba  out  1  A < B.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, eq=1, ab=0, ba=0; operand registers and digit counter cleared.
- States:
  - IDLE: on start=1, latch a, b and is_signed, load the digit counter with N=WIDTH/DIGIT, clear the running flags (eq_r=1, ab_r=0, ba_r=0), then go to BUSY.
  - BUSY: each edge compares the current top digit of both shift registers.
    - If eq_r=1, the first non-equal bit within the digit, scanned MSB-first, sets ab_r or ba_r and clears eq_r.
    - Once eq_r=0, ab_r and ba_r are frozen.
    - Both shift registers shift left by DIGIT and the counter decrements.
    - When the counter reaches 0, go to DONE.
  - DONE: for one cycle, done=1 and eq/ab/ba present the final flags. Next state is IDLE.
- Signed mode: the MSB of A and B is inverted before compare; this is applied to the first (top) digit only.
- Latency: start accepted at edge k; done is high in the cycle after edge k+N; busy is high in the cycles after edges k through k+N−1.
- Result outputs: update only in DONE and hold through IDLE. Exactly one of eq/ab/ba is 1 at all times after reset.
- start while busy=1 or in DONE: ignored, no queueing.
- start in the same cycle that done=1: ignored; the accepting cycle is the one after DONE.
- Operands changing after acceptance have no effect.
- rst asserted mid-compare: immediate return to IDLE with reset outputs; no done pulse.
- DIGIT=WIDTH: N=1; done appears 2 edges after start.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: in BUSY, once eq_r has cleared, the next edge goes to DONE regardless of the counter. Latency becomes the 1-based MSB-first index of the first differing digit, or N when the operands are equal.
- Undefined: fixed latency N; no data-dependent timing.
- Flag values are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - state enum cmp_state_t {IDLE, BUSY, DONE};
  - typedef cmp_res_t struct {eq, ab, ba};
  - function to derive N and the counter width, $clog2(N+1).
- Sub-module cmp_digit:
  - Combinational DIGIT-bit MSB-first chain.
  - Inputs: a_d, b_d, eqi.
  - Outputs: eq, ab, ba.
  - Built from a generate loop of per-bit compare cells.
  - Instantiated once in seq_cmp.

Test Plan (all defaults unless noted):
- Unsigned greater: a=0x80000000, b=0x7FFFFFFF, is_signed=0 → done 9 edges after start (N=8); ab=1, eq=0, ba=0.
- Signed reversal: same operands, is_signed=1 → ba=1 (−2^31 < 2^31−1); a=0xFFFFFFFF, b=0x00000001, is_signed=1 → ba=1; with is_signed=0 → ab=1.
- Equal and timing: a=b=0xDEADBEEF → eq=1 after exactly 9 edges.
  - Under SEQ_CMP_EARLY_EXIT_EN: a=0x10000000, b=0x00000000 → done after 2 edges, ab=1.
  - Under SEQ_CMP_EARLY_EXIT_EN: a=0x00000001, b=0x00000000 → done after 9 edges.
- Handshake: start held high continuously with a=5, b=3 → one accept per 10 cycles (IDLE, 8×BUSY, DONE); done pulses are single-cycle; operand changes mid-compare are ignored; ab=1 throughout.
- Reset mid-compare: assert rst at busy cycle 4 → busy=0, done=0, eq=1, ab=0, ba=0 within the same cycle; no done pulse follows; the next start completes normally.
- Randomised sweep, WIDTH=16 and DIGIT=1/8/16: 40% equal pairs, both modes → flags match a signed/unsigned golden compare; coverage of eq/ab/ba each ≥ 1.
